// File: rtl/axis_segin_shift_fifo_pkg.sv
// Shared helpers for the segmented AXI Stream datapath (segin/segout FIFOs).
package axis_segin_shift_fifo_pkg;

    // Width of one segment lane for a bus split into n lanes.
    function automatic int seg_width(input int bus_w, input int n);
        return bus_w / n;
    endfunction

    // Number of byte enables covering w data bits.
    function automatic int byte_count(input int w);
        return w / 8;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int depth_cbits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_segin_shift_fifo_if.sv
// Segmented AXI Stream bundle: LANES lanes of SEG_W bits, each with its own
// valid/ready. tuser/tlast are a single shared sideband.
interface axis_segin_shift_fifo_if #(
    parameter int LANES  = 4,
    parameter int SEG_W  = 16,
    parameter int USER_W = 4
);
    logic [LANES-1:0][SEG_W-1:0]   tdata;
    logic [LANES-1:0][SEG_W/8-1:0] tkeep;
    logic [USER_W-1:0]             tuser;
    logic                          tlast;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_segin_shift_fifo_lane.sv
// Single-lane shift-register FIFO. Entry 0 is the head; reads shift every
// entry down by one, writes land just above the last valid entry.
module axis_seg_lane_fifo
    import axis_segin_shift_fifo_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int SB_W   = 0,
    parameter int DEPTH  = 3,
    localparam int EW    = DATA_W + SB_W,
    localparam int CW    = depth_cbits(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] din,
    input  logic          rd,
    output logic [EW-1:0] head,
    output logic [CW-1:0] count,
    output logic          nonempty
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_idx;
    logic          wr;

    // Ready depends only on occupancy: no write-through on a full lane.
    assign in_ready = (cnt != CW'(DEPTH));
    assign wr       = in_valid && in_ready;
    // rd is only ever asserted with cnt != 0, so cnt-1 never wraps.
    assign wr_idx   = rd ? cnt - 1'b1 : cnt;
    assign count    = cnt;
    assign nonempty = (cnt != '0);

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        // Top entry "shifts" from itself, i.e. holds its value on a read.
        localparam int UP = (k < DEPTH - 1) ? k + 1 : k;
        logic [EW-1:0] q;

        // Write wins over shift when both target this entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (wr && wr_idx == CW'(k)) begin
                q <= din;
            end else if (rd) begin
                q <= g_ent[UP].q;
            end
        end
    end

    assign head = g_ent[0].q;

endmodule

// File: rtl/axis_segin_shift_fifo.sv
// Segment reassembly: NUM_SEGMENTS independent lane FIFOs joined into one
// full-width stream. A beat leaves only when every lane has one queued.
module axis_segin_shift_fifo
    import axis_segin_shift_fifo_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int NUM_SEGMENTS    = 4,
    parameter int BUFFER_DEPTH    = 3,
    localparam int AXIS_SEG_WIDTH     = seg_width(AXIS_BUS_WIDTH, NUM_SEGMENTS),
    localparam int NUM_SEG_BYTES      = byte_count(AXIS_SEG_WIDTH),
    localparam int NUM_BUS_BYTES      = byte_count(AXIS_BUS_WIDTH),
    localparam int BUFFER_DEPTH_CBITS = depth_cbits(BUFFER_DEPTH)
) (
    input  logic aclk,
    input  logic aresetn,
    axis_segin_shift_fifo_if.slave  axis_in,
    axis_segin_shift_fifo_if.master axis_out,
    output logic [NUM_SEGMENTS-1:0][BUFFER_DEPTH_CBITS-1:0] axis_in_lane_count
);
    localparam int LANE_W = AXIS_SEG_WIDTH + NUM_SEG_BYTES;
    localparam int TOP_SB = AXIS_USER_WIDTH + 1;

    logic [NUM_SEGMENTS-1:0][AXIS_SEG_WIDTH-1:0] data_head;
    logic [NUM_SEGMENTS-1:0][NUM_SEG_BYTES-1:0]  keep_head;
    logic [NUM_BUS_BYTES-1:0]                    keep_flat;
    logic [TOP_SB-1:0]                           sb_head;
    logic [NUM_SEGMENTS-1:0]                     lane_ready;
    logic [NUM_SEGMENTS-1:0]                     lane_nonempty;
    logic                                        out_valid;
    logic                                        rd;

    assign out_valid = &lane_nonempty;
    assign rd        = out_valid && axis_out.tready[0];

    for (genvar j = 0; j < NUM_SEGMENTS; j++) begin : g_lane
        // Only the highest lane carries tlast/tuser.
        localparam int SB_W = (j == NUM_SEGMENTS - 1) ? TOP_SB : 0;
        logic [LANE_W+SB_W-1:0] din;
        logic [LANE_W+SB_W-1:0] head;

        if (SB_W > 0) begin : g_sb
            assign din     = {axis_in.tlast, axis_in.tuser, axis_in.tkeep[j], axis_in.tdata[j]};
            assign sb_head = head[LANE_W +: TOP_SB];
        end else begin : g_nosb
            assign din = {axis_in.tkeep[j], axis_in.tdata[j]};
        end

        axis_seg_lane_fifo #(
            .DATA_W (LANE_W),
            .SB_W   (SB_W),
            .DEPTH  (BUFFER_DEPTH)
        ) u_lane (
            .clk      (aclk),
            .rst_n    (aresetn),
            .in_valid (axis_in.tvalid[j]),
            .in_ready (lane_ready[j]),
            .din      (din),
            .rd       (rd),
            .head     (head),
            .count    (axis_in_lane_count[j]),
            .nonempty (lane_nonempty[j])
        );

        assign data_head[j] = head[AXIS_SEG_WIDTH-1:0];
        assign keep_head[j] = head[AXIS_SEG_WIDTH +: NUM_SEG_BYTES];
    end

    // Outputs come straight from the lane heads: registered, no input path.
    assign keep_flat        = keep_head;
    assign axis_in.tready   = lane_ready;
    assign axis_out.tdata   = data_head;
    assign axis_out.tkeep   = keep_flat;
    assign axis_out.tuser   = sb_head[AXIS_USER_WIDTH-1:0];
    assign axis_out.tlast   = sb_head[AXIS_USER_WIDTH];
    assign axis_out.tvalid  = out_valid;

endmodule

// File: tb/tb_axis_segin_shift_fifo.sv
// Directed bench for axis_segin_shift_fifo (64-bit bus, 4 lanes, depth 3).
// Stimulus queues expected output beats; a negedge monitor pops and compares.
module tb_axis_segin_shift_fifo;

    logic aclk = 1'b0;
    logic aresetn;
    logic [3:0][1:0] lane_count;

    axis_segin_shift_fifo_if #(.LANES(4), .SEG_W(16), .USER_W(4)) in_if ();
    axis_segin_shift_fifo_if #(.LANES(1), .SEG_W(64), .USER_W(4)) out_if ();

    axis_segin_shift_fifo #(
        .AXIS_BUS_WIDTH  (64),
        .AXIS_USER_WIDTH (4),
        .NUM_SEGMENTS    (4),
        .BUFFER_DEPTH    (3)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .axis_in            (in_if.slave),
        .axis_out           (out_if.master),
        .axis_in_lane_count (lane_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic [3:0] u, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.user = u; b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    // Drive lane data 16'h<base>j<b>-style: base | (j<<4) | beat.
    task automatic set_lanes(input logic [3:0] vmask, input logic [15:0] base, input int beat);
        for (int j = 0; j < 4; j++) begin
            in_if.tdata[j] = base | 16'(j << 4) | 16'(beat);
            in_if.tkeep[j] = 2'b11;
        end
        in_if.tvalid = vmask;
    endtask

    function automatic logic [63:0] cat(input logic [15:0] base, input int beat);
        logic [63:0] r;
        for (int j = 0; j < 4; j++) r[j*16 +: 16] = base | 16'(j << 4) | 16'(beat);
        return r;
    endfunction

    // Scoreboard monitor: every accepted output beat must match the queue head.
    always @(negedge aclk) begin
        if (aresetn && out_if.tvalid[0] && out_if.tready[0]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: unexpected beat data %h (no beat expected)", out_if.tdata);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (out_if.tdata !== e.data || out_if.tkeep !== e.keep ||
                    out_if.tuser !== e.user || out_if.tlast !== e.last) begin
                    n_err++;
                    $display("FAIL out_beat: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                             out_if.tdata, out_if.tkeep, out_if.tuser, out_if.tlast,
                             e.data, e.keep, e.user, e.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        in_if.tdata   = '0;
        in_if.tkeep   = '0;
        in_if.tuser   = '0;
        in_if.tlast   = 1'b0;
        in_if.tvalid  = '0;
        out_if.tready = 1'b0;
        #1;
        chk("rst_tvalid", 64'(out_if.tvalid), 64'h0);
        chk("rst_tready", 64'(in_if.tready), 64'hF);
        chk("rst_counts", 64'(lane_count), 64'h0);
        chk("rst_tdata", out_if.tdata, 64'h0);
        chk("rst_side", {59'h0, out_if.tlast, out_if.tuser}, 64'h0);
        #21 aresetn = 1'b1;
        cycle();

        // Aligned streaming.
        out_if.tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_lanes(4'hF, 16'hA000, b);
            chk("stream_ready", 64'(in_if.tready), 64'hF);
            push_beat(cat(16'hA000, b), 8'hFF, 4'h0, 1'b0);
            cycle();
            if (b == 0) chk("stream_latency", 64'(out_if.tvalid), 64'h1);
            else        chk("stream_steady_cnt", 64'(lane_count), 64'h55);
        end
        in_if.tvalid = '0;
        cycle();
        chk("stream_drained", {55'h0, out_if.tvalid, lane_count}, 64'h0);

        // Skew: lane 0 runs three beats ahead.
        for (int b = 0; b < 3; b++) begin
            set_lanes(4'h1, 16'hB000, b);
            chk("skew_l0_ready", 64'(in_if.tready[0]), 64'h1);
            cycle();
        end
        in_if.tvalid = '0;
        chk("skew_l0_full", 64'(in_if.tready), 64'hE);
        chk("skew_no_valid", 64'(out_if.tvalid), 64'h0);
        chk("skew_cnt_full", 64'(lane_count), 64'h03);
        set_lanes(4'hE, 16'hB000, 0);
        push_beat(cat(16'hB000, 0), 8'hFF, 4'h0, 1'b0);
        cycle();
        in_if.tvalid = '0;
        chk("skew_join_valid", 64'(out_if.tvalid), 64'h1);
        chk("skew_l0_still_full", 64'(in_if.tready[0]), 64'h0);
        cycle();
        chk("skew_l0_ready_back", 64'(in_if.tready), 64'hF);
        chk("skew_cnt_after_rd", 64'(lane_count), 64'h02);
        for (int b = 1; b < 3; b++) begin
            set_lanes(4'hE, 16'hB000, b);
            push_beat(cat(16'hB000, b), 8'hFF, 4'h0, 1'b0);
            cycle();
        end
        in_if.tvalid = '0;
        cycle();
        chk("skew_drained", 64'(lane_count), 64'h0);

        // Backpressure until full.
        out_if.tready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            set_lanes(4'hF, 16'hC000, b);
            chk("bp_ready", 64'(in_if.tready), (b < 3) ? 64'hF : 64'h0);
            if (b < 3) push_beat(cat(16'hC000, b), 8'hFF, 4'h0, 1'b0);
            cycle();
        end
        in_if.tvalid = '0;
        chk("bp_counts", 64'(lane_count), 64'hFF);
        chk("bp_valid", 64'(out_if.tvalid), 64'h1);
        out_if.tready = 1'b1;
        repeat (3) cycle();
        chk("bp_empty", {55'h0, out_if.tvalid, lane_count}, 64'h0);

        // Simultaneous read and write at count 1.
        out_if.tready = 1'b0;
        set_lanes(4'hF, 16'hD000, 0);
        push_beat(cat(16'hD000, 0), 8'hFF, 4'h0, 1'b0);
        cycle();
        chk("rw_cnt1", 64'(lane_count), 64'h55);
        out_if.tready = 1'b1;
        set_lanes(4'hF, 16'hD000, 1);
        push_beat(cat(16'hD000, 1), 8'hFF, 4'h0, 1'b0);
        cycle();
        in_if.tvalid = '0;
        chk("rw_cnt_stays", 64'(lane_count), 64'h55);
        chk("rw_head_new", out_if.tdata, cat(16'hD000, 1));
        cycle();
        chk("rw_drained", 64'(lane_count), 64'h0);

        // Sideband on lane 3, varied tkeep.
        set_lanes(4'hF, 16'hE000, 0);
        in_if.tkeep = {2'b11, 2'b00, 2'b10, 2'b01};
        in_if.tlast = 1'b1;
        in_if.tuser = 4'h5;
        push_beat(cat(16'hE000, 0), 8'hC9, 4'h5, 1'b1);
        cycle();
        // tlast/tuser driven while only lane 0 is valid: must be ignored.
        set_lanes(4'h1, 16'hE000, 1);
        in_if.tuser = 4'hA;
        cycle();
        set_lanes(4'hE, 16'hE000, 1);
        in_if.tlast = 1'b0;
        in_if.tuser = 4'h0;
        push_beat(cat(16'hE000, 1), 8'hFF, 4'h0, 1'b0);
        cycle();
        in_if.tvalid = '0;
        cycle();

        // Asynchronous reset with partially filled lanes.
        out_if.tready = 1'b0;
        set_lanes(4'h7, 16'hF000, 0);
        cycle();
        set_lanes(4'h5, 16'hF000, 1);
        cycle();
        set_lanes(4'h4, 16'hF000, 2);
        cycle();
        in_if.tvalid = '0;
        chk("ar_pre_counts", 64'(lane_count), 64'h36);
        #2 aresetn = 1'b0;
        #1;
        chk("ar_counts", 64'(lane_count), 64'h0);
        chk("ar_tvalid", 64'(out_if.tvalid), 64'h0);
        chk("ar_tready", 64'(in_if.tready), 64'hF);
        chk("ar_tdata", out_if.tdata, 64'h0);
        #3 aresetn = 1'b1;
        cycle();
        out_if.tready = 1'b1;
        set_lanes(4'hF, 16'h1200, 3);
        push_beat(cat(16'h1200, 3), 8'hFF, 4'h0, 1'b0);
        cycle();
        in_if.tvalid = '0;
        repeat (3) cycle();

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
